date_sequencer: RTL and testbench

DATE_SEQUENCER -- requirements
Module: date_sequencer

---
 rtl/calendar_pkg.sv | 39 +++
 rtl/bcd_date_incr.sv | 61 ++++++
 rtl/date_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_date_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar definitions: controller state encoding, month lengths,
// leap-year rule and the days-in-month lookup.
// Build option: GREGORIAN_CENTURY_RULE_EN selects the full Gregorian leap rule;
// without it every fourth year is a leap year, which is correct for 1901-2099.
package calendar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADV    = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [4:0] DAYS_28 = 5'd28;
    localparam logic [4:0] DAYS_29 = 5'd29;
    localparam logic [4:0] DAYS_30 = 5'd30;
    localparam logic [4:0] DAYS_31 = 5'd31;

    function automatic logic is_leap(input logic [11:0] y);
`ifdef GREGORIAN_CENTURY_RULE_EN
        return (((y % 12'd4) == 12'd0) && ((y % 12'd100) != 12'd0)) ||
               ((y % 12'd400) == 12'd0);
`else
        return (y % 12'd4) == 12'd0;
`endif
    endfunction

    // Month is binary; out-of-range months fall into the 31-day default and
    // are rejected separately by the load check.
    function automatic logic [4:0] days_in_month(input logic [7:0] month,
                                                 input logic [11:0] year);
        case (month)
            8'd2:                    return is_leap(year) ? DAYS_29 : DAYS_28;
            8'd4, 8'd6, 8'd9, 8'd11: return DAYS_30;
            default:                 return DAYS_31;
        endcase
    endfunction

endpackage

// File: rtl/bcd_date_incr.sv
// Combinational next-day calculator on a BCD day/month + binary year.
// Also exposes the binary day/month and the month's day limit so the
// controller can validate a loaded date with the same logic.
// Build option: GREGORIAN_CENTURY_RULE_EN (via calendar_pkg leap rule).
module bcd_date_incr
    import calendar_pkg::*;
#(
    parameter int MIN_YEAR = 2000,
    parameter int MAX_YEAR = 2099
) (
    input  logic [3:0]  day10,
    input  logic [3:0]  day1,
    input  logic [3:0]  month10,
    input  logic [3:0]  month1,
    input  logic [11:0] year,
    output logic [7:0]  day_bin,
    output logic [7:0]  month_bin,
    output logic [4:0]  day_limit,
    output logic [3:0]  next_day10,
    output logic [3:0]  next_day1,
    output logic [3:0]  next_month10,
    output logic [3:0]  next_month1,
    output logic [11:0] next_year
);

    localparam logic [11:0] MIN_Y = 12'(MIN_YEAR);
    localparam logic [11:0] MAX_Y = 12'(MAX_YEAR);

    assign day_bin   = 8'(day10) * 8'd10 + 8'(day1);
    assign month_bin = 8'(month10) * 8'd10 + 8'(month1);
    assign day_limit = days_in_month(month_bin, year);

    // Next date: BCD digit carries, month rollover, year wrap to MIN_YEAR.
    always_comb begin
        next_day10   = day10;
        next_day1    = day1;
        next_month10 = month10;
        next_month1  = month1;
        next_year    = year;
        if (day_bin >= {3'd0, day_limit}) begin
            next_day10 = 4'd0;
            next_day1  = 4'd1;
            if (month_bin >= 8'd12) begin
                next_month10 = 4'd0;
                next_month1  = 4'd1;
                next_year    = (year == MAX_Y) ? MIN_Y : year + 12'd1;
            end else if (month1 == 4'd9) begin
                next_month10 = month10 + 4'd1;
                next_month1  = 4'd0;
            end else begin
                next_month1 = month1 + 4'd1;
            end
        end else if (day1 == 4'd9) begin
            next_day10 = day10 + 4'd1;
            next_day1  = 4'd0;
        end else begin
            next_day1 = day1 + 4'd1;
        end
    end

endmodule

// File: rtl/date_sequencer.sv
// Calendar date register with midnight advance and validated parallel load.
// Build option: GREGORIAN_CENTURY_RULE_EN selects the century leap rule.
//
// Load handshake: the requester raises load_req with ld_* stable and holds
// it until it sees load_ack (one cycle, during COMMIT or a rejecting CHECK);
// it must drop load_req right after that cycle so IDLE does not reload.
// load_err accompanies load_ack on rejection. The committed date and the
// registered sync_out/date_changed pulses appear together in the cycle after
// COMMIT/ADV, i.e. 2 cycles after load_req and 1 cycle after day_tick.
module date_sequencer
    import calendar_pkg::*;
#(
    parameter int MIN_YEAR = 2000,
    parameter int MAX_YEAR = 2099,
    parameter int RST_YEAR = 2024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        day_tick,
    input  logic        load_req,
    input  logic [3:0]  ld_day10,
    input  logic [3:0]  ld_day1,
    input  logic [3:0]  ld_month10,
    input  logic [3:0]  ld_month1,
    input  logic [11:0] ld_year,
    output logic [3:0]  day10,
    output logic [3:0]  day1,
    output logic [3:0]  month10,
    output logic [3:0]  month1,
    output logic [11:0] year,
    output logic        load_ack,
    output logic        load_err,
    output logic        date_changed,
    output logic        sync_out,
    output logic        busy
);

    state_t      state, state_next;
    logic        pend_tick, pend_next;
    logic [3:0]  sh_day10, sh_day1, sh_month10, sh_month1;
    logic [11:0] sh_year;

    logic        check_sel;
    logic [3:0]  in_day10, in_day1, in_month10, in_month1;
    logic [11:0] in_year;
    logic [7:0]  day_bin, month_bin;
    logic [4:0]  day_limit;
    logic [3:0]  nx_day10, nx_day1, nx_month10, nx_month1;
    logic [11:0] nx_year;
    logic        digits_ok, fields_ok, year_ok, shadow_valid;

    // The incrementer sees the shadow date during CHECK so its day-limit
    // logic validates loads; otherwise it sees the live date for ADV.
    assign check_sel  = (state == CHECK);
    assign in_day10   = check_sel ? sh_day10   : day10;
    assign in_day1    = check_sel ? sh_day1    : day1;
    assign in_month10 = check_sel ? sh_month10 : month10;
    assign in_month1  = check_sel ? sh_month1  : month1;
    assign in_year    = check_sel ? sh_year    : year;

    bcd_date_incr #(
        .MIN_YEAR (MIN_YEAR),
        .MAX_YEAR (MAX_YEAR)
    ) u_incr (
        .day10        (in_day10),
        .day1         (in_day1),
        .month10      (in_month10),
        .month1       (in_month1),
        .year         (in_year),
        .day_bin      (day_bin),
        .month_bin    (month_bin),
        .day_limit    (day_limit),
        .next_day10   (nx_day10),
        .next_day1    (nx_day1),
        .next_month10 (nx_month10),
        .next_month1  (nx_month1),
        .next_year    (nx_year)
    );

    assign digits_ok = (sh_day10 <= 4'd9) && (sh_day1 <= 4'd9) &&
                       (sh_month10 <= 4'd9) && (sh_month1 <= 4'd9);
    assign fields_ok = (month_bin >= 8'd1) && (month_bin <= 8'd12) &&
                       (day_bin >= 8'd1) && (day_bin <= {3'd0, day_limit});
    assign year_ok   = (sh_year >= 12'(MIN_YEAR)) && (sh_year <= 12'(MAX_YEAR));
    assign shadow_valid = digits_ok && fields_ok && year_ok;

    assign busy     = (state != IDLE);
    assign load_err = check_sel && !shadow_valid;
    assign load_ack = (state == COMMIT) || load_err;

    // State and pending-tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pend_tick <= 1'b0;
        end else begin
            state     <= state_next;
            pend_tick <= pend_next;
        end
    end

    // Next state and pending-tick bookkeeping. A tick that meets a pending
    // tick in IDLE re-arms the flag so neither is lost.
    always_comb begin
        state_next = state;
        pend_next  = pend_tick;
        case (state)
            IDLE: begin
                if (load_req) begin
                    state_next = CHECK;
                    if (day_tick) pend_next = 1'b1;
                end else if (day_tick || pend_tick) begin
                    state_next = ADV;
                    pend_next  = day_tick && pend_tick;
                end
            end
            ADV: begin
                state_next = IDLE;
                if (day_tick) pend_next = 1'b1;
            end
            CHECK: begin
                state_next = shadow_valid ? COMMIT : IDLE;
                if (day_tick) pend_next = 1'b1;
            end
            COMMIT: begin
                state_next = IDLE;
                pend_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                pend_next  = 1'b0;
            end
        endcase
    end

    // Capture the requested date as CHECK is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_day10   <= 4'd0;
            sh_day1    <= 4'd0;
            sh_month10 <= 4'd0;
            sh_month1  <= 4'd0;
            sh_year    <= 12'd0;
        end else if (state == IDLE && load_req) begin
            sh_day10   <= ld_day10;
            sh_day1    <= ld_day1;
            sh_month10 <= ld_month10;
            sh_month1  <= ld_month1;
            sh_year    <= ld_year;
        end
    end

    // Date register plus the pulses that mark a new date.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            day10        <= 4'd0;
            day1         <= 4'd1;
            month10      <= 4'd0;
            month1       <= 4'd1;
            year         <= 12'(RST_YEAR);
            date_changed <= 1'b0;
            sync_out     <= 1'b0;
        end else begin
            date_changed <= (state == ADV);
            sync_out     <= (state == COMMIT);
            if (state == ADV) begin
                day10   <= nx_day10;
                day1    <= nx_day1;
                month10 <= nx_month10;
                month1  <= nx_month1;
                year    <= nx_year;
            end else if (state == COMMIT) begin
                day10   <= sh_day10;
                day1    <= sh_day1;
                month10 <= sh_month10;
                month1  <= sh_month1;
                year    <= sh_year;
            end
        end
    end

endmodule

// File: tb/tb_date_sequencer.sv
// Bench for date_sequencer: reset values, a table of load/advance vectors,
// hand-written pending-tick and reset sequences, randomized loads and ticks
// against a day-arithmetic calendar model, and the leap rule at 1900.
// Build option: GREGORIAN_CENTURY_RULE_EN changes the 1900 expectation.
module tb_date_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        day_tick = 1'b0, load_req = 1'b0;
    logic        day_tick_b = 1'b0, load_req_b = 1'b0;
    logic [3:0]  ld_day10 = 4'd0, ld_day1 = 4'd0, ld_month10 = 4'd0, ld_month1 = 4'd0;
    logic [11:0] ld_year = 12'd0;

    logic [3:0]  day10, day1, month10, month1;
    logic [11:0] year;
    logic        load_ack, load_err, date_changed, sync_out, busy;
    logic [3:0]  day10_b, day1_b, month10_b, month1_b;
    logic [11:0] year_b;
    logic        load_ack_b, load_err_b, date_changed_b, sync_out_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int dc_count = 0;

    always #5 clk = ~clk;

    date_sequencer u_dut (
        .clk(clk), .reset(reset), .day_tick(day_tick), .load_req(load_req),
        .ld_day10(ld_day10), .ld_day1(ld_day1), .ld_month10(ld_month10),
        .ld_month1(ld_month1), .ld_year(ld_year),
        .day10(day10), .day1(day1), .month10(month10), .month1(month1), .year(year),
        .load_ack(load_ack), .load_err(load_err), .date_changed(date_changed),
        .sync_out(sync_out), .busy(busy)
    );

    date_sequencer #(.MIN_YEAR(1900)) u_dut_b (
        .clk(clk), .reset(reset), .day_tick(day_tick_b), .load_req(load_req_b),
        .ld_day10(ld_day10), .ld_day1(ld_day1), .ld_month10(ld_month10),
        .ld_month1(ld_month1), .ld_year(ld_year),
        .day10(day10_b), .day1(day1_b), .month10(month10_b), .month1(month1_b), .year(year_b),
        .load_ack(load_ack_b), .load_err(load_err_b), .date_changed(date_changed_b),
        .sync_out(sync_out_b), .busy(busy_b)
    );

    always @(negedge clk) if (date_changed === 1'b1) dc_count++;

    // ---------------- reference calendar model ----------------
    function automatic bit m_leap(input int y);
`ifdef GREGORIAN_CENTURY_RULE_EN
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
        return (y % 4 == 0);
`endif
    endfunction

    function automatic int m_dim(input int y, input int m);
        int t [12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && m_leap(y)) return 29;
        return t[m - 1];
    endfunction

    function automatic int m_next(input int date, input int miny, input int maxy);
        int y, m, d;
        y = date / 10000;
        m = (date / 100) % 100;
        d = date % 100;
        if (d < m_dim(y, m)) d++;
        else begin
            d = 1;
            if (m < 12) m++;
            else begin
                m = 1;
                y = (y == maxy) ? miny : y + 1;
            end
        end
        return y * 10000 + m * 100 + d;
    endfunction

    function automatic bit m_valid(input int d10, input int d1, input int m10,
                                   input int m1, input int y, input int miny, input int maxy);
        int m, d;
        if (d10 > 9 || d1 > 9 || m10 > 9 || m1 > 9) return 0;
        m = m10 * 10 + m1;
        d = d10 * 10 + d1;
        if (m < 1 || m > 12) return 0;
        if (y < miny || y > maxy) return 0;
        return (d >= 1) && (d <= m_dim(y, m));
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int dut_date(input bit sel);
        if (sel)
            return int'(year_b) * 10000 + (int'(month10_b) * 10 + int'(month1_b)) * 100 +
                   int'(day10_b) * 10 + int'(day1_b);
        return int'(year) * 10000 + (int'(month10) * 10 + int'(month1)) * 100 +
               int'(day10) * 10 + int'(day1);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit sel);
        if (sel) day_tick_b = 1'b1; else day_tick = 1'b1;
        step;
        day_tick = 1'b0;
        day_tick_b = 1'b0;
    endtask

    task automatic do_load(input bit sel, input logic [3:0] a10, input logic [3:0] a1,
                           input logic [3:0] b10, input logic [3:0] b1, input logic [11:0] y,
                           output bit err, output bit synced);
        bit acked;
        acked = 1'b0;
        err = 1'b0;
        ld_day10 = a10; ld_day1 = a1; ld_month10 = b10; ld_month1 = b1; ld_year = y;
        if (sel) load_req_b = 1'b1; else load_req = 1'b1;
        for (int i = 0; i < 8 && !acked; i++) begin
            step;
            if ((sel ? load_ack_b : load_ack) === 1'b1) begin
                acked = 1'b1;
                err = sel ? load_err_b : load_err;
            end
        end
        load_req = 1'b0;
        load_req_b = 1'b0;
        check("load_ack_seen", int'(acked), 1);
        step;
        synced = sel ? sync_out_b : sync_out;
    endtask

    typedef struct {
        logic [3:0]  d10, d1, m10, m1;
        logic [11:0] y;
        bit          err;
        int          next;
    } vec_t;

    function automatic vec_t mk(input int d10, input int d1, input int m10, input int m1,
                                input int y, input bit err, input int next);
        vec_t v;
        v.d10 = 4'(d10); v.d1 = 4'(d1); v.m10 = 4'(m10); v.m1 = 4'(m1);
        v.y = 12'(y); v.err = err; v.next = next;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        vec_t vecs [21];
        bit err, synced;
        int pre, exp, dc0, loaded;

        vecs[0]  = mk(2, 8, 0, 2, 2024, 0, 20240229);
        vecs[1]  = mk(2, 9, 0, 2, 2024, 0, 20240301);
        vecs[2]  = mk(2, 8, 0, 2, 2023, 0, 20230301);
        vecs[3]  = mk(2, 9, 0, 2, 2023, 1, 0);
        vecs[4]  = mk(3, 1, 0, 4, 2023, 1, 0);
        vecs[5]  = mk(3, 0, 0, 4, 2023, 0, 20230501);
        vecs[6]  = mk(3, 1, 1, 2, 2024, 0, 20250101);
        vecs[7]  = mk(3, 1, 1, 2, 2099, 0, 20000101);
        vecs[8]  = mk(0, 1, 1, 3, 2024, 1, 0);
        vecs[9]  = mk(1, 0, 0, 0, 2024, 1, 0);
        vecs[10] = mk(0, 0, 0, 5, 2024, 1, 0);
        vecs[11] = mk(0, 10, 0, 5, 2024, 1, 0);
        vecs[12] = mk(0, 1, 0, 6, 1999, 1, 0);
        vecs[13] = mk(0, 1, 0, 1, 2100, 1, 0);
        vecs[14] = mk(1, 9, 0, 9, 2024, 0, 20240920);
        vecs[15] = mk(3, 0, 0, 9, 2024, 0, 20241001);
        vecs[16] = mk(2, 9, 0, 2, 2000, 0, 20000301);
        vecs[17] = mk(3, 2, 0, 1, 2024, 1, 0);
        vecs[18] = mk(3, 1, 0, 1, 2000, 0, 20000201);
        vecs[19] = mk(0, 9, 1, 0, 2024, 0, 20241010);
        vecs[20] = mk(0, 1, 10, 0, 2024, 1, 0);

        // reset values
        step;
        check("rst_date", dut_date(0), 20240101);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        step;
        check("rst_date_after", dut_date(0), 20240101);
        check("rst_ack", int'(load_ack), 0);
        check("rst_err", int'(load_err), 0);
        check("rst_dc", int'(date_changed), 0);
        check("rst_sync", int'(sync_out), 0);

        // first tick: new date and a single-cycle date_changed
        tick(0);
        check("adv_busy", int'(busy), 1);
        check("adv_old_date", dut_date(0), 20240101);
        step;
        check("adv_date", dut_date(0), 20240102);
        check("adv_dc_hi", int'(date_changed), 1);
        step;
        check("adv_dc_lo", int'(date_changed), 0);

        // table of loads followed by one tick
        for (int i = 0; i < 21; i++) begin
            pre = dut_date(0);
            loaded = int'(vecs[i].y) * 10000 + (int'(vecs[i].m10) * 10 + int'(vecs[i].m1)) * 100 +
                     int'(vecs[i].d10) * 10 + int'(vecs[i].d1);
            do_load(0, vecs[i].d10, vecs[i].d1, vecs[i].m10, vecs[i].m1, vecs[i].y, err, synced);
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].err));
            check($sformatf("vec%0d_sync", i), int'(synced), vecs[i].err ? 0 : 1);
            if (vecs[i].err) begin
                check($sformatf("vec%0d_unchanged", i), dut_date(0), pre);
            end else begin
                check($sformatf("vec%0d_loaded", i), dut_date(0), loaded);
                tick(0);
                step;
                check($sformatf("vec%0d_next", i), dut_date(0), vecs[i].next);
            end
        end

        // load and tick together: load wins, pended tick discarded by COMMIT
        dc0 = dc_count;
        ld_day10 = 4'd1; ld_day1 = 4'd5; ld_month10 = 4'd0; ld_month1 = 4'd6; ld_year = 12'd2024;
        load_req = 1'b1;
        day_tick = 1'b1;
        step;
        day_tick = 1'b0;
        check("both_no_err", int'(load_err), 0);
        step;
        check("both_ack", int'(load_ack), 1);
        load_req = 1'b0;
        step;
        check("both_date", dut_date(0), 20240615);
        check("both_sync", int'(sync_out), 1);
        repeat (4) step;
        check("both_no_adv_date", dut_date(0), 20240615);
        check("both_no_adv_dc", dc_count - dc0, 0);
        check("both_idle", int'(busy), 0);

        // tick during a rejecting CHECK stays pending and advances afterwards
        ld_day10 = 4'd3; ld_day1 = 4'd0; ld_month10 = 4'd0; ld_month1 = 4'd2; ld_year = 12'd2023;
        load_req = 1'b1;
        step;
        day_tick = 1'b1;
        check("rej_ack", int'(load_ack), 1);
        check("rej_err", int'(load_err), 1);
        load_req = 1'b0;
        step;
        day_tick = 1'b0;
        repeat (3) step;
        check("rej_pend_adv", dut_date(0), 20240616);

        // tick during ADV is pended: net two days
        dc0 = dc_count;
        tick(0);
        tick(0);
        repeat (4) step;
        check("pend_date", dut_date(0), 20240618);
        check("pend_dc_count", dc_count - dc0, 2);

        // randomized loads and ticks against the model
        do_load(0, 4'd2, 4'd0, 4'd0, 4'd7, 12'd2050, err, synced);
        exp = 20500720;
        check("rand_seed_date", dut_date(0), exp);
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                tick(0);
                exp = m_next(exp, 2000, 2099);
            end else if (op == 1) begin
                tick(0);
                tick(0);
                exp = m_next(m_next(exp, 2000, 2099), 2000, 2099);
            end else begin
                int y, m, d, d1v;
                bit ok;
                y = $urandom_range(1995, 2104);
                m = $urandom_range(0, 13);
                d = $urandom_range(0, 32);
                d1v = d % 10;
                if ($urandom_range(0, 7) == 0) d1v = $urandom_range(10, 15);
                ok = m_valid(d / 10, d1v, m / 10, m % 10, y, 2000, 2099);
                do_load(0, 4'(d / 10), 4'(d1v), 4'(m / 10), 4'(m % 10), 12'(y), err, synced);
                check($sformatf("rand%0d_err", it), int'(err), ok ? 0 : 1);
                if (ok) exp = y * 10000 + m * 100 + d;
            end
            repeat (4) step;
            check($sformatf("rand%0d_date", it), dut_date(0), exp);
        end

        // leap rule at 1900 on the MIN_YEAR=1900 instance
        do_load(1, 4'd2, 4'd8, 4'd0, 4'd2, 12'd1900, err, synced);
        check("y1900_err", int'(err), 0);
        check("y1900_loaded", dut_date(1), 19000228);
        tick(1);
        step;
`ifdef GREGORIAN_CENTURY_RULE_EN
        check("y1900_next", dut_date(1), 19000301);
`else
        check("y1900_next", dut_date(1), 19000229);
`endif

        // reset during CHECK abandons the load
        ld_day10 = 4'd0; ld_day1 = 4'd3; ld_month10 = 4'd0; ld_month1 = 4'd3; ld_year = 12'd2030;
        load_req = 1'b1;
        step;
        check("rstchk_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("rstchk_date", dut_date(0), 20240101);
        check("rstchk_ack", int'(load_ack), 0);
        check("rstchk_busy_lo", int'(busy), 0);
        load_req = 1'b0;
        #1;
        reset = 1'b0;
        step;
        check("rstchk_ack_after", int'(load_ack), 0);
        check("rstchk_sync_after", int'(sync_out), 0);
        step;
        check("rstchk_date_after", dut_date(0), 20240101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
